// File: rtl/ar_breakpoint_engine_if.sv
// CPU-side bus seen by the breakpoint engine: access strobes, register window, trigger outputs.
interface ar_breakpoint_engine_if;
    logic [23:1] cpuaddress;
    logic        cpurd;
    logic        cpuhwr;
    logic        cpulwr;
    logic        dma;
    logic        boot;
    logic        reg_sel;
    logic [7:1]  reg_adr;
    logic        reg_wr;
    logic [15:0] datain;
    logic [15:0] dataout;
    logic        int7;
    logic        frozen;
    logic [2:0]  hit_id;

    modport master (
        output cpuaddress, cpurd, cpuhwr, cpulwr, dma, boot,
        output reg_sel, reg_adr, reg_wr, datain,
        input  dataout, int7, frozen, hit_id
    );

    modport slave (
        input  cpuaddress, cpurd, cpuhwr, cpulwr, dma, boot,
        input  reg_sel, reg_adr, reg_wr, datain,
        output dataout, int7, frozen, hit_id
    );
endinterface

// File: rtl/ar_breakpoint_engine.sv
// Address breakpoint channels with pass counters driving the INT7 freeze handshake and re-arm FSM.
// Trigger reaches int7 one clock after the qualifying access edge; register reads are combinational.
module ar_breakpoint_engine #(
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    ar_breakpoint_engine_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_PENDING = 3'd2,
        ST_FROZEN  = 3'd3,
        ST_REARM   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [23:1]       r_adr    [NUM_BP];
    logic [CNT_W-1:0]  r_reload [NUM_BP];
    logic [CNT_W-1:0]  r_count  [NUM_BP];
    logic [NUM_BP-1:0] r_en;
    logic [NUM_BP-1:0] r_rd;
    logic [NUM_BP-1:0] r_wr;
    logic [NUM_BP-1:0] r_once;
    logic              r_arm;
    logic [2:0]        r_hit_id;
    logic              r_strobe_d;

    logic              w_strobe;
    logic              w_qual;
    logic              w_ack;
    logic              w_cart;
    logic              w_reg_wr;
    logic              w_status_wr;
    logic              w_arm_wr;
    logic [2:0]        w_ch;
    logic [2:0]        w_reg;
    logic [5:0]        w_glob_idx;
    logic [NUM_BP-1:0] w_match;
    logic [NUM_BP-1:0] w_fire;
    logic              w_any_fire;
    logic [2:0]        w_fire_id;
    logic [15:0]       w_rdata;

    // Accesses count once per strobe assertion, and never for DMA, bootloader or register traffic.
    assign w_strobe    = bus.cpurd | bus.cpuhwr | bus.cpulwr;
    assign w_qual      = w_strobe & ~r_strobe_d & ~bus.dma & ~bus.boot & ~bus.reg_sel;
    assign w_ack       = (bus.cpuaddress == 23'h7FFFFF) & bus.cpurd;
    assign w_cart      = (bus.cpuaddress[23:19] == 5'b01000);

    assign w_ch        = bus.reg_adr[6:4];
    assign w_reg       = bus.reg_adr[3:1];
    assign w_glob_idx  = bus.reg_adr[6:1];
    assign w_reg_wr    = bus.reg_sel & bus.reg_wr;
    assign w_status_wr = w_reg_wr &  bus.reg_adr[7] & (w_glob_idx == 6'd0);
    assign w_arm_wr    = w_reg_wr &  bus.reg_adr[7] & (w_glob_idx == 6'd1);

    always_comb begin
        w_match = '0;
        w_fire  = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            w_match[i] = (r_state == ST_ARMED) && w_qual && r_en[i] &&
                         (r_adr[i] == bus.cpuaddress) &&
                         ((bus.cpurd && r_rd[i]) || ((bus.cpuhwr || bus.cpulwr) && r_wr[i]));
            w_fire[i]  = w_match[i] && (r_count[i] == '0);
        end
    end

    // Descending scan so the lowest firing channel is reported.
    always_comb begin
        w_fire_id = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_fire[i]) begin
                w_fire_id = 3'(i);
            end
        end
    end

    assign w_any_fire = |w_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_arm) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_any_fire) begin
                    w_state_nxt = ST_PENDING;
                end else if (!r_arm) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (w_ack) begin
                    w_state_nxt = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (w_status_wr) begin
                    w_state_nxt = ST_REARM;
                end
            end
            ST_REARM: begin
                // Swallow the first non-cartridge access: the return into the breakpointed instruction.
                if (w_qual && !w_cart) begin
                    w_state_nxt = r_arm ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm      <= 1'b0;
            r_hit_id   <= '0;
            r_strobe_d <= 1'b0;
        end else begin
            r_strobe_d <= w_strobe;
            if (w_arm_wr) begin
                r_arm <= bus.datain[0];
            end
            if (w_any_fire) begin
                r_hit_id <= w_fire_id;
            end
        end
    end

    // Register writes come after the counter update so a write always wins on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en   <= '0;
            r_rd   <= '0;
            r_wr   <= '0;
            r_once <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                r_adr[i]    <= '0;
                r_reload[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (w_match[i]) begin
                    if (w_fire[i]) begin
                        r_count[i] <= r_reload[i];
                        if (r_once[i]) begin
                            r_en[i] <= 1'b0;
                        end
                    end else begin
                        r_count[i] <= r_count[i] - CNT_W'(1);
                    end
                end
                if (w_reg_wr && !bus.reg_adr[7] && (w_ch == 3'(i))) begin
                    case (w_reg)
                        3'd0: r_adr[i][23:16] <= bus.datain[7:0];
                        3'd1: r_adr[i][15:1]  <= bus.datain[15:1];
                        3'd2: begin
                            r_en[i]   <= bus.datain[0];
                            r_rd[i]   <= bus.datain[1];
                            r_wr[i]   <= bus.datain[2];
                            r_once[i] <= bus.datain[3];
                        end
                        3'd3: begin
                            r_reload[i] <= bus.datain[CNT_W-1:0];
                            r_count[i]  <= bus.datain[CNT_W-1:0];
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.reg_adr[7]) begin
            if (w_glob_idx == 6'd0) begin
                w_rdata = {9'd0, r_hit_id, 1'b0, 3'(r_state)};
            end else if (w_glob_idx == 6'd1) begin
                w_rdata = {15'd0, r_arm};
            end
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (w_ch == 3'(i)) begin
                    case (w_reg)
                        3'd0: w_rdata = {8'd0, r_adr[i][23:16]};
                        3'd1: w_rdata = {r_adr[i][15:1], 1'b0};
                        3'd2: w_rdata = {12'd0, r_once[i], r_wr[i], r_rd[i], r_en[i]};
                        3'd3: w_rdata[CNT_W-1:0] = r_reload[i];
                        3'd4: w_rdata[CNT_W-1:0] = r_count[i];
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.dataout = (bus.reg_sel && bus.cpurd) ? w_rdata : 16'd0;
    assign bus.int7    = (r_state == ST_PENDING);
    assign bus.frozen  = (r_state == ST_FROZEN);
    assign bus.hit_id  = r_hit_id;

endmodule

// File: tb/tb_ar_breakpoint_engine.sv
// Bench for ar_breakpoint_engine: directed freeze/re-arm scenarios then randomized traffic vs a behavioural model.
module tb_ar_breakpoint_engine;
    localparam int NUM_BP = 4;
    localparam int CNT_W  = 8;
    localparam int S_IDLE = 0, S_ARMED = 1, S_PENDING = 2, S_FROZEN = 3, S_REARM = 4;

    logic clk = 1'b0;
    logic reset;
    ar_breakpoint_engine_if bus();

    ar_breakpoint_engine #(.NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [23:1] m_adr [8];
    bit          m_en [8], m_rd [8], m_wr [8], m_once [8];
    int          m_reload [8], m_count [8];
    int          m_state, m_hit;
    bit          m_arm, m_prev;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit strobe, qual, ack, stwr;
        int win;
        strobe = bus.cpurd | bus.cpuhwr | bus.cpulwr;
        if (reset) begin
            for (int c = 0; c < 8; c++) begin
                m_adr[c] = '0; m_en[c] = 0; m_rd[c] = 0; m_wr[c] = 0; m_once[c] = 0;
                m_reload[c] = 0; m_count[c] = 0;
            end
            m_state = S_IDLE; m_hit = 0; m_arm = 0; m_prev = 0;
            return;
        end
        qual   = strobe && !m_prev && !bus.dma && !bus.boot && !bus.reg_sel;
        m_prev = strobe;
        win    = -1;
        if (m_state == S_ARMED && qual) begin
            for (int c = 0; c < NUM_BP; c++) begin
                if (m_en[c] && m_adr[c] == bus.cpuaddress &&
                    ((bus.cpurd && m_rd[c]) || ((bus.cpuhwr || bus.cpulwr) && m_wr[c]))) begin
                    if (m_count[c] == 0) begin
                        m_count[c] = m_reload[c];
                        if (m_once[c]) m_en[c] = 0;
                        if (win < 0) win = c;
                    end else begin
                        m_count[c] = m_count[c] - 1;
                    end
                end
            end
        end
        ack  = (bus.cpuaddress == 23'h7FFFFF) && bus.cpurd;
        stwr = bus.reg_sel && bus.reg_wr && bus.reg_adr == 7'h40;
        case (m_state)
            S_IDLE:    if (m_arm) m_state = S_ARMED;
            S_ARMED:   if (win >= 0) begin m_state = S_PENDING; m_hit = win; end
                       else if (!m_arm) m_state = S_IDLE;
            S_PENDING: if (ack) m_state = S_FROZEN;
            S_FROZEN:  if (stwr) m_state = S_REARM;
            default:   if (qual && bus.cpuaddress[23:19] != 5'b01000) m_state = m_arm ? S_ARMED : S_IDLE;
        endcase
        if (bus.reg_sel && bus.reg_wr) begin
            if (bus.reg_adr[7]) begin
                if (bus.reg_adr[6:1] == 6'd1) m_arm = bus.datain[0];
            end else if (int'(bus.reg_adr[6:4]) < NUM_BP) begin
                int c;
                c = int'(bus.reg_adr[6:4]);
                case (bus.reg_adr[3:1])
                    3'd0: m_adr[c][23:16] = bus.datain[7:0];
                    3'd1: m_adr[c][15:1]  = bus.datain[15:1];
                    3'd2: begin
                        m_en[c] = bus.datain[0]; m_rd[c] = bus.datain[1];
                        m_wr[c] = bus.datain[2]; m_once[c] = bus.datain[3];
                    end
                    3'd3: begin
                        m_reload[c] = int'(bus.datain) % (1 << CNT_W);
                        m_count[c]  = m_reload[c];
                    end
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [15:0] mread();
        int c;
        if (!(bus.reg_sel && bus.cpurd)) return 16'd0;
        if (bus.reg_adr[7]) begin
            if (bus.reg_adr[6:1] == 6'd0) return 16'(m_hit * 16 + m_state);
            if (bus.reg_adr[6:1] == 6'd1) return 16'(m_arm);
            return 16'd0;
        end
        c = int'(bus.reg_adr[6:4]);
        if (c >= NUM_BP) return 16'd0;
        case (bus.reg_adr[3:1])
            3'd0: return {8'd0, m_adr[c][23:16]};
            3'd1: return {m_adr[c][15:1], 1'b0};
            3'd2: return 16'(m_once[c] * 8 + m_wr[c] * 4 + m_rd[c] * 2 + m_en[c]);
            3'd3: return 16'(m_reload[c]);
            3'd4: return 16'(m_count[c]);
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("int7",    32'(bus.int7),    32'(m_state == S_PENDING));
            chk("frozen",  32'(bus.frozen),  32'(m_state == S_FROZEN));
            chk("hit_id",  32'(bus.hit_id),  32'(m_hit));
            chk("dataout", 32'(bus.dataout), 32'(mread()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpuaddress = '0; bus.cpurd = 0; bus.cpuhwr = 0; bus.cpulwr = 0;
        bus.dma = 0; bus.boot = 0; bus.reg_sel = 0; bus.reg_adr = '0;
        bus.reg_wr = 0; bus.datain = '0;
    endtask

    function automatic logic [7:1] ca(input int ch, input int r);
        logic [7:1] v;
        v = {1'b0, 3'(ch), 3'(r)};
        return v;
    endfunction

    task automatic wr_reg(input logic [7:1] a, input logic [15:0] d);
        idle(); bus.reg_sel = 1; bus.reg_wr = 1; bus.reg_adr = a; bus.datain = d;
        tick(); idle(); tick();
    endtask

    task automatic chk_rd(input string nm, input logic [7:1] a, input logic [15:0] exp);
        logic [15:0] d;
        idle(); bus.reg_sel = 1; bus.cpurd = 1; bus.reg_adr = a;
        #1 d = bus.dataout;
        chk(nm, 32'(d), 32'(exp));
        tick(); idle(); tick();
    endtask

    task automatic cpu_acc(input logic [23:1] a, input bit rd, input bit wr, input int n, input bit d, input bit b);
        idle(); bus.cpuaddress = a; bus.cpurd = rd; bus.cpuhwr = wr; bus.dma = d; bus.boot = b;
        repeat (n) tick();
        idle(); tick();
    endtask

    task automatic prog_ch(input int ch, input logic [23:1] a, input logic [15:0] ctrl, input logic [15:0] rl);
        wr_reg(ca(ch, 0), {8'd0, a[23:16]});
        wr_reg(ca(ch, 1), {a[15:1], 1'b0});
        wr_reg(ca(ch, 3), rl);
        wr_reg(ca(ch, 2), ctrl);
    endtask

    task automatic exit_freeze();
        cpu_acc(23'h7FFFFF, 1, 0, 1, 0, 0);
        wr_reg(7'h40, 16'h0000);
        cpu_acc(23'h000800, 1, 0, 1, 0, 0);
    endtask

    function automatic logic [23:1] pick_addr();
        case ($urandom_range(0, 6))
            0: return 23'h000080;
            1: return 23'h010000;
            2: return 23'h002000;
            3: return 23'h200008;
            4: return 23'h7FFFFF;
            5: return 23'h000800;
            default: return 23'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        chk_en = 1;
        reset = 0;
        tick();

        // Reset state
        chk("rst_int7", 32'(bus.int7), 0);
        chk("rst_frozen", 32'(bus.frozen), 0);
        chk("rst_hit", 32'(bus.hit_id), 0);
        chk_rd("rst_status", 7'h40, 16'h0000);
        chk_rd("rst_arm", 7'h41, 16'h0000);

        // Basic read breakpoint at $000100 and ack
        prog_ch(0, 23'h000080, 16'h0003, 16'h0000);
        wr_reg(7'h41, 16'h0001);
        chk_rd("armed_status", 7'h40, 16'h0001);
        cpu_acc(23'h000080, 1, 0, 1, 0, 0);
        chk("t1_int7", 32'(bus.int7), 1);
        chk_rd("t1_status", 7'h40, 16'h0002);
        cpu_acc(23'h7FFFFF, 1, 0, 1, 0, 0);
        chk("t1_ack_int7", 32'(bus.int7), 0);
        chk("t1_frozen", 32'(bus.frozen), 1);
        chk_rd("t1_status_fz", 7'h40, 16'h0003);

        // Re-arm: cart access ignored, first outside access consumed, next one re-triggers
        wr_reg(7'h40, 16'h0000);
        chk_rd("rearm_status", 7'h40, 16'h0004);
        cpu_acc(23'h200008, 1, 0, 1, 0, 0);
        chk_rd("rearm_cart", 7'h40, 16'h0004);
        cpu_acc(23'h000080, 1, 0, 1, 0, 0);
        chk("rearm_consumed", 32'(bus.int7), 0);
        chk_rd("rearm_to_armed", 7'h40, 16'h0001);
        cpu_acc(23'h000080, 1, 0, 1, 0, 0);
        chk("rearm_retrig", 32'(bus.int7), 1);
        exit_freeze();
        wr_reg(ca(0, 2), 16'h0000);

        // Pass counter: RELOAD=2 write breakpoint fires on third hit
        prog_ch(1, 23'h010000, 16'h0005, 16'h0002);
        chk_rd("cnt_init", ca(1, 4), 16'h0002);
        cpu_acc(23'h010000, 0, 1, 1, 0, 0);
        chk_rd("cnt_1", ca(1, 4), 16'h0001);
        cpu_acc(23'h010000, 0, 1, 1, 0, 0);
        chk("cnt_no_int", 32'(bus.int7), 0);
        chk_rd("cnt_0", ca(1, 4), 16'h0000);
        cpu_acc(23'h010000, 0, 1, 1, 0, 0);
        chk("cnt_fire", 32'(bus.int7), 1);
        chk("cnt_hit", 32'(bus.hit_id), 1);
        chk_rd("cnt_reload", ca(1, 4), 16'h0002);
        exit_freeze();

        // Two channels fire together: lowest index reported, both reload
        prog_ch(1, 23'h002000, 16'h0003, 16'h0001);
        prog_ch(3, 23'h002000, 16'h0003, 16'h0001);
        cpu_acc(23'h002000, 1, 0, 1, 0, 0);
        chk_rd("dual_c1_0", ca(1, 4), 16'h0000);
        chk_rd("dual_c3_0", ca(3, 4), 16'h0000);
        cpu_acc(23'h002000, 1, 0, 1, 0, 0);
        chk("dual_int7", 32'(bus.int7), 1);
        chk("dual_hit", 32'(bus.hit_id), 1);
        chk_rd("dual_c1_rl", ca(1, 4), 16'h0001);
        chk_rd("dual_c3_rl", ca(3, 4), 16'h0001);
        exit_freeze();

        // DMA/boot suppression and held strobe
        prog_ch(0, 23'h000080, 16'h0003, 16'h0001);
        cpu_acc(23'h000080, 1, 0, 1, 1, 0);
        chk_rd("dma_cnt", ca(0, 4), 16'h0001);
        cpu_acc(23'h000080, 1, 0, 1, 0, 1);
        chk_rd("boot_cnt", ca(0, 4), 16'h0001);
        chk("dmaboot_int7", 32'(bus.int7), 0);
        cpu_acc(23'h000080, 1, 0, 5, 0, 0);
        chk_rd("held_cnt", ca(0, 4), 16'h0000);
        chk("held_int7", 32'(bus.int7), 0);
        cpu_acc(23'h000080, 1, 0, 1, 0, 0);
        chk("pend_int7", 32'(bus.int7), 1);

        // Reset while pending, with a register write on the reset edge
        idle(); reset = 1;
        bus.reg_sel = 1; bus.reg_wr = 1; bus.reg_adr = ca(0, 1); bus.datain = 16'hABCD;
        tick();
        chk("rstp_int7", 32'(bus.int7), 0);
        idle(); reset = 0; tick();
        chk_rd("rstp_status", 7'h40, 16'h0000);
        chk_rd("rstp_arm", 7'h41, 16'h0000);
        chk_rd("rstp_adrl", ca(0, 1), 16'h0000);
        chk_rd("rstp_ctrl", ca(0, 2), 16'h0000);
        chk_rd("rstp_reload", ca(1, 3), 16'h0000);
        chk_rd("rstp_count", ca(3, 4), 16'h0000);
        wr_reg(ca(5, 1), 16'h1234);
        chk_rd("ch5_adrl", ca(5, 1), 16'h0000);

        // Once channel clears its enable on firing
        prog_ch(2, 23'h003000, 16'h000B, 16'h0000);
        wr_reg(7'h41, 16'h0001);
        cpu_acc(23'h003000, 1, 0, 1, 0, 0);
        chk("once_fire", 32'(bus.int7), 1);
        chk_rd("once_ctrl", ca(2, 2), 16'h000A);
        exit_freeze();
        cpu_acc(23'h003000, 1, 0, 1, 0, 0);
        chk("once_no_refire", 32'(bus.int7), 0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            int op;
            logic [23:1] p;
            idle();
            reset = ($urandom_range(0, 299) == 0);
            op = $urandom_range(0, 99);
            p  = pick_addr();
            if (op < 12) begin
                bus.reg_sel = 1; bus.reg_wr = 1;
                if ($urandom_range(0, 3) == 0) begin
                    bus.reg_adr = ($urandom_range(0, 1) == 0) ? 7'h40 : 7'h41;
                    bus.datain  = 16'($urandom_range(0, 3) != 0);
                end else begin
                    int r;
                    r = $urandom_range(0, 5);
                    bus.reg_adr = ca($urandom_range(0, 5), r);
                    case (r)
                        0: bus.datain = {8'd0, p[23:16]};
                        1: bus.datain = {p[15:1], 1'b0};
                        2: bus.datain = 16'($urandom_range(0, 15));
                        default: bus.datain = 16'($urandom_range(0, 3));
                    endcase
                end
            end else if (op < 25) begin
                bus.reg_sel = 1; bus.cpurd = 1; bus.reg_adr = 7'($urandom);
            end else if (op < 75) begin
                bus.cpuaddress = p;
                bus.cpurd  = 1'($urandom_range(0, 1));
                bus.cpuhwr = 1'($urandom_range(0, 1));
                bus.cpulwr = ($urandom_range(0, 3) == 0);
                bus.dma    = ($urandom_range(0, 9) == 0);
                bus.boot   = ($urandom_range(0, 9) == 0);
            end
            tick();
        end
        idle(); reset = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ar_breakpoint_engine.md
Name: ar_breakpoint_engine

Overview:
- Parametrised breakpoint/freeze-trigger unit for the Action Replay cartridge path.
- Provides NUM_BP independent address-compare channels. Each channel has an access-type filter and a pass counter.
- Owns the INT7 request/acknowledge handshake and an explicit re-arm state machine, so a breakpoint re-triggers correctly after an immediate exit from the freezer.
- Sits beside the cartridge decoder. The CPU programs it through a register window that the decoder selects.

Parameters:
- NUM_BP, 4: number of breakpoint channels; legal range 1..8.
- CNT_W, 8: pass-counter width; legal range 1..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpuaddress  in  23  CPU word address [23:1]
- cpurd  in  1  CPU read strobe
- cpuhwr  in  1  CPU high-byte write strobe
- cpulwr  in  1  CPU low-byte write strobe
- dma  in  1  bus owned by DMA; no compares while high
- boot  in  1  bootloader active; no compares while high
- reg_sel  in  1  register window selected by cartridge decoder
- reg_adr  in  7  register address [7:1]
- reg_wr  in  1  register write (word)
- datain  in  16  CPU write data
- dataout  out  16  register read data; 0 when reg_sel=0 or cpurd=0
- int7  out  1  level-7 interrupt request
- frozen  out  1  high in FROZEN state
- hit_id  out  3  index of the last triggering channel

Behaviour:
- Reset: state=IDLE, int7=0, frozen=0, hit_id=0, global arm=0, all channel regs and counters=0, dataout=0.

Access qualification:
- strobe = cpurd|cpuhwr|cpulwr.
- An access counts once, on the first clk where strobe=1 and the previous cycle had strobe=0.
- It is qualified only if dma=0, boot=0 and reg_sel=0.

Per-channel registers (reg_adr[7]=0; channel=reg_adr[6:4], reg=reg_adr[3:1]; channel>=NUM_BP reads 0, writes ignored):
- 0 ADRH: [7:0] = address[23:16].
- 1 ADRL: [15:1] = address[15:1].
- 2 CTRL: [0] en, [1] match read, [2] match write, [3] once (clear en after trigger).
- 3 RELOAD: [CNT_W-1:0].
- 4 COUNT: read-only, current count. Any write to RELOAD also loads COUNT.

Global registers (reg_adr[7]=1):
- 0 STATUS read: [2:0] state code, [6:4] hit_id.
- 0 STATUS write: any write while FROZEN is the exit command.
- 1 ARM: [0] arm.

Channel match:
- en=1, cpuaddress==stored address, and (cpurd&rd | (cpuhwr|cpulwr)&wr) on a qualified access, in state ARMED.
- On match with COUNT!=0: COUNT decrements.
- On match with COUNT==0: channel fires, COUNT reloads from RELOAD.
- RELOAD=N therefore triggers on hit N+1.
- All matching channels update their counters in the same cycle.
- If several channels fire in one cycle, the lowest index wins hit_id. All firing channels reload.

State machine (codes 0..4):
- IDLE: arm=1 -> ARMED.
- ARMED:
  - any channel fires -> PENDING next clk; int7=1 on that same edge (1-clk latency from the qualifying edge); hit_id latched.
  - arm=0 with no fire -> IDLE.
- PENDING: int7=1. On ack (cpuaddress==23'h7FFFFF & cpurd) -> FROZEN, int7=0.
- FROZEN: frozen=1; compares off. A STATUS write -> REARM.
- REARM:
  - compares off.
  - The first qualified access with cpuaddress[23:19]!=5'b01000 (outside the cartridge) is consumed without compare; next state is ARMED if arm=1, else IDLE.
  - Result: the instruction at the breakpoint is re-executed once without an immediate re-trigger.
- Writes to ARM in PENDING/FROZEN/REARM only update the arm bit; the bit takes effect at the next IDLE/ARMED decision.
- once=1: the channel's en clears on the same edge it fires.

Reset mid-operation:
- reset in any state -> IDLE, int7=0 the following cycle.
- Registers written on the same edge as reset keep their reset values.

Register reads:
- dataout is combinational from the register file, gated by reg_sel&cpurd.
- Unused bits read 0.

Test Plan:
- Channel 0 programmed to $000100, rd=1, en=1, RELOAD=0; arm=1; CPU read of $000100 -> int7=1 one clk later, hit_id=0, state=PENDING; ack read of $FFFFFE -> int7=0, frozen=1.
- RELOAD=2 on channel 1 at $020000, write match only -> first two writes leave COUNT 2->1->0 with int7=0; third write -> int7=1; COUNT reads back 2.
- Channels 1 and 3 both set to $004000 -> single read fires both; hit_id=1; both COUNTs reload.
- From FROZEN: STATUS write, CPU read at $400010 (cart, ignored), read of breakpoint $000100 (consumed), second read of $000100 -> int7=1 again.
- A read with dma=1 or boot=1 at the breakpoint address -> no count change, int7 stays 0. A held cpurd lasting 5 clks -> exactly one decrement.
- reset asserted in PENDING -> int7=0, state=IDLE, all registers read 0. A channel index >= NUM_BP reads 0.
